// File: rtl/cmos_ddr3_wr_ctrl.sv
// Camera-side DDR3 write controller: buffers RGB565 pixels in a FIFO and
// issues fixed-length write bursts into two ping-ponged frame buffers.
module cmos_ddr3_wr_ctrl #(
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FIFO_DEPTH  = 256,
  parameter logic [27:0] FRAME_BASE0 = 28'h0000000,
  parameter logic [27:0] FRAME_BASE1 = 28'h0200000,
  localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
  input  logic        cam_pclk,
  input  logic        rst,
  input  logic        cmos_frame_vsync,
  input  logic        cmos_frame_valid,
  input  logic [15:0] cmos_frame_data,
  input  logic [27:0] ddr3_addr_max,
  output logic        wr_burst_req,
  output logic [27:0] wr_burst_addr,
  output logic [9:0]  wr_burst_len,
  input  logic        wr_burst_ack,
  input  logic        wr_data_req,
  output logic [15:0] wr_data,
  input  logic        wr_burst_done,
  output logic        frame_done,
  output logic        rd_frame_sel,
  output logic        fifo_overflow,
  output logic [AW:0] fifo_level
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT_DONE} state_t;

  localparam logic [27:0] BURST_LEN_W = 28'(BURST_LEN);
  localparam logic [AW:0] DEPTH_W     = (AW + 1)'(FIFO_DEPTH);

  state_t        state, state_nxt;
  logic          vs_r1, vs_r2, vs_edge;
  logic          pending, armed, start, sel;
  logic [27:0]   frame_words, words_issued, words_acc, rem;
  logic [9:0]    burst_n, data_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   mem [FIFO_DEPTH];
  logic          fifo_full, push_req, push, pop;

  assign vs_edge   = vs_r1 & ~vs_r2;
  // A pending vsync is serviced only once the FSM is back in IDLE.
  assign start     = (state == IDLE) && (vs_edge || pending);
  assign fifo_full = (fifo_level == DEPTH_W);
  assign push_req  = armed && cmos_frame_valid && !pending && !vs_edge &&
                     (words_acc < frame_words);
  assign push      = push_req && !fifo_full;
  assign pop       = (state == DATA) && wr_data_req;
  assign rem       = frame_words - words_issued;
  assign burst_n   = (rem < BURST_LEN_W) ? rem[9:0] : BURST_LEN_W[9:0];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (!start && rem != 28'd0 && 28'(fifo_level) >= 28'(burst_n))
          state_nxt = REQ;
      REQ:
        if (wr_burst_ack) state_nxt = DATA;
      DATA:
        if (pop && data_cnt == wr_burst_len - 10'd1) state_nxt = WAIT_DONE;
      WAIT_DONE:
        if (wr_burst_done) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cam_pclk) begin
    if (push) mem[wr_ptr] <= cmos_frame_data;
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      state         <= IDLE;
      vs_r1         <= 1'b0;
      vs_r2         <= 1'b0;
      pending       <= 1'b0;
      armed         <= 1'b0;
      sel           <= 1'b0;
      frame_words   <= '0;
      words_issued  <= '0;
      words_acc     <= '0;
      data_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      fifo_overflow <= 1'b0;
      wr_burst_req  <= 1'b0;
      wr_burst_addr <= FRAME_BASE0;
      wr_burst_len  <= '0;
      wr_data       <= '0;
      frame_done    <= 1'b0;
      rd_frame_sel  <= 1'b0;
    end else begin
      state        <= state_nxt;
      vs_r1        <= cmos_frame_vsync;
      vs_r2        <= vs_r1;
      frame_done   <= 1'b0;
      wr_burst_req <= (state_nxt == REQ);

      if (vs_edge && state != IDLE) pending <= 1'b1;
      if (push_req && fifo_full) fifo_overflow <= 1'b1;

      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        words_acc <= words_acc + 28'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        wr_data  <= mem[rd_ptr];
        data_cnt <= data_cnt + 10'd1;
      end
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;

      if (state == IDLE && state_nxt == REQ) begin
        wr_burst_len  <= burst_n;
        wr_burst_addr <= (sel ? FRAME_BASE1 : FRAME_BASE0) + words_issued;
        data_cnt      <= '0;
      end

      if (state == WAIT_DONE && wr_burst_done) begin
        words_issued <= words_issued + 28'(wr_burst_len);
        if (words_issued + 28'(wr_burst_len) == frame_words) begin
          frame_done   <= 1'b1;
          rd_frame_sel <= sel;
          sel          <= ~sel;
        end
      end

      // Frame start flushes the FIFO and rewinds the current buffer.
      if (start) begin
        pending      <= 1'b0;
        armed        <= 1'b1;
        frame_words  <= ddr3_addr_max;
        words_issued <= '0;
        words_acc    <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        fifo_level   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cmos_ddr3_wr_ctrl.sv
// Directed bench for cmos_ddr3_wr_ctrl: behavioural DDR write port plus
// expected queues for burst address/length and written data.
module tb_cmos_ddr3_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmos_frame_vsync;
  logic        cmos_frame_valid;
  logic [15:0] cmos_frame_data;
  logic [27:0] ddr3_addr_max;
  logic        wr_burst_req;
  logic [27:0] wr_burst_addr;
  logic [9:0]  wr_burst_len;
  logic        wr_burst_ack;
  logic        wr_data_req;
  logic [15:0] wr_data;
  logic        wr_burst_done;
  logic        frame_done;
  logic        rd_frame_sel;
  logic        fifo_overflow;
  logic [8:0]  fifo_level;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;
  int bursts_done = 0;
  int max_level = 0;
  int ack_delay = 2;
  bit ddr_en = 1'b1;
  bit in_data = 1'b0;

  logic [15:0] exp_q[$];
  logic [27:0] exp_addr_q[$];
  logic [9:0]  exp_len_q[$];

  cmos_ddr3_wr_ctrl dut (
    .cam_pclk(clk), .rst(rst),
    .cmos_frame_vsync(cmos_frame_vsync), .cmos_frame_valid(cmos_frame_valid),
    .cmos_frame_data(cmos_frame_data), .ddr3_addr_max(ddr3_addr_max),
    .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr),
    .wr_burst_len(wr_burst_len), .wr_burst_ack(wr_burst_ack),
    .wr_data_req(wr_data_req), .wr_data(wr_data),
    .wr_burst_done(wr_burst_done), .frame_done(frame_done),
    .rd_frame_sel(rd_frame_sel), .fifo_overflow(fifo_overflow),
    .fifo_level(fifo_level)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
  end

  // DDR write-port model
  always begin
    logic [9:0] blen;
    @(negedge clk);
    if (ddr_en && wr_burst_req) begin
      if (exp_addr_q.size() == 0) begin
        check("burst_unexpected", 32'd1, 32'd0);
      end else begin
        check("burst_addr", 32'(wr_burst_addr), 32'(exp_addr_q.pop_front()));
        check("burst_len", 32'(wr_burst_len), 32'(exp_len_q.pop_front()));
      end
      blen = wr_burst_len;
      repeat (ack_delay) @(negedge clk);
      wr_burst_ack = 1'b1;
      @(negedge clk);
      wr_burst_ack = 1'b0;
      check("req_drop_after_ack", 32'(wr_burst_req), 32'd0);
      in_data = 1'b1;
      for (int i = 0; i < int'(blen); i++) begin
        wr_data_req = 1'b1;
        @(negedge clk);
        if (exp_q.size() == 0) check("data_unexpected", 32'(wr_data), 32'hDEAD);
        else check("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
      end
      wr_data_req   = 1'b0;
      wr_burst_done = 1'b1;
      @(negedge clk);
      wr_burst_done = 1'b0;
      in_data = 1'b0;
      bursts_done++;
    end
  end

  // driver tasks
  task automatic send_pixels(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      cmos_frame_valid = 1'b1;
      cmos_frame_data  = base + 16'(i);
      @(negedge clk);
    end
    cmos_frame_valid = 1'b0;
  endtask

  task automatic pulse_vsync();
    cmos_frame_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cmos_frame_vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_burst(input logic [27:0] addr, input logic [9:0] len,
                              input logic [15:0] dbase);
    exp_addr_q.push_back(addr);
    exp_len_q.push_back(len);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(dbase + 16'(i));
  endtask

  task automatic wait_frames(input int target, input string tag);
    int budget = 3000;
    while (done_cnt < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_bursts(input int target, input string tag);
    int budget = 3000;
    while (bursts_done < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 32'(bursts_done), 32'(target));
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    cmos_frame_vsync = 1'b0;
    cmos_frame_valid = 1'b0;
    cmos_frame_data  = '0;
    ddr3_addr_max    = 28'd128;
    wr_burst_ack = 1'b0;
    wr_data_req  = 1'b0;
    wr_burst_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_req", 32'(wr_burst_req), 32'd0);
    check("rst_addr", 32'(wr_burst_addr), 32'h0000000);
    check("rst_len", 32'(wr_burst_len), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_sel", 32'(rd_frame_sel), 32'd0);
    check("rst_ovf", 32'(fifo_overflow), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);

    // pixels before the first vsync are ignored
    send_pixels(16'h0900, 80);
    repeat (3) @(negedge clk);
    check("unarmed_level", 32'(fifo_level), 32'd0);
    check("unarmed_req", 32'(wr_burst_req), 32'd0);

    // frame 1: 128 words into buffer 0
    ddr3_addr_max = 28'd128;
    expect_burst(28'h0000000, 10'd64, 16'h0000);
    expect_burst(28'h0000040, 10'd64, 16'h0040);
    pulse_vsync();
    send_pixels(16'h0000, 64);
    check("lat_level64", 32'(fifo_level), 32'd64);
    check("lat_req_low", 32'(wr_burst_req), 32'd0);
    @(negedge clk);
    check("lat_req_high", 32'(wr_burst_req), 32'd1);
    send_pixels(16'h0040, 64);
    wait_frames(1, "f1_frame_done");
    repeat (4) @(negedge clk);
    check("f1_done_once", 32'(done_cnt), 32'd1);
    check("f1_rd_sel", 32'(rd_frame_sel), 32'd0);
    check("f1_level", 32'(fifo_level), 32'd0);

    // frame 2: 100 words into buffer 1, extra pixels dropped
    ddr3_addr_max = 28'd100;
    expect_burst(28'h0200000, 10'd64, 16'h0100);
    expect_burst(28'h0200040, 10'd36, 16'h0140);
    pulse_vsync();
    send_pixels(16'h0100, 105);
    wait_frames(2, "f2_frame_done");
    repeat (4) @(negedge clk);
    check("f2_bursts", 32'(bursts_done), 32'd4);
    check("f2_rd_sel", 32'(rd_frame_sel), 32'd1);
    check("f2_level", 32'(fifo_level), 32'd0);

    // frame 3: vsync while DATA; burst completes, frame restarts in buffer 0
    ddr3_addr_max = 28'd128;
    expect_burst(28'h0000000, 10'd64, 16'h0200);
    pulse_vsync();
    send_pixels(16'h0200, 70);
    budget = 200;
    while (!in_data && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("f3_in_data", 32'(in_data), 32'd1);
    ddr3_addr_max = 28'd64;
    pulse_vsync();
    wait_bursts(5, "f3_burst_finished");
    repeat (5) @(negedge clk);
    check("f3_no_frame_done", 32'(done_cnt), 32'd2);
    check("f3_flushed", 32'(fifo_level), 32'd0);
    check("f3_rd_sel_kept", 32'(rd_frame_sel), 32'd1);
    check("f3_no_req", 32'(wr_burst_req), 32'd0);
    check("f3_data_drained", 32'(exp_q.size()), 32'd0);
    expect_burst(28'h0000000, 10'd64, 16'h0300);
    send_pixels(16'h0300, 64);
    wait_frames(3, "f3_restart_done");
    repeat (4) @(negedge clk);
    check("f3_rd_sel", 32'(rd_frame_sel), 32'd0);

    // overflow: ack withheld while pixels keep arriving
    ddr_en = 1'b0;
    ddr3_addr_max = 28'd1000;
    pulse_vsync();
    send_pixels(16'h0400, 300);
    check("ovf_level_full", 32'(fifo_level), 32'd256);
    check("ovf_flag", 32'(fifo_overflow), 32'd1);
    check("ovf_req_pending", 32'(wr_burst_req), 32'd1);
    check("ovf_addr", 32'(wr_burst_addr), 32'h0200000);
    repeat (20) @(negedge clk);
    check("ovf_sticky", 32'(fifo_overflow), 32'd1);
    check("ovf_max_level", 32'(max_level <= 256), 32'd1);

    // reset while requesting
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_cleared", 32'(wr_burst_req), 32'd0);
    check("rst_level_cleared", 32'(fifo_level), 32'd0);
    check("rst_sel_cleared", 32'(rd_frame_sel), 32'd0);
    check("rst_addr_base0", 32'(wr_burst_addr), 32'h0000000);
    check("rst_ovf_cleared", 32'(fifo_overflow), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("exp_data_empty", 32'(exp_q.size()), 32'd0);
    check("exp_burst_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
